// File: rtl/median_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : median_line_ctrl
// Purpose  : Line-buffer sequencer for the 5x5 binary median window. Tracks
//            video timing, drives the circular shared BRAM address/enable,
//            counts columns/lines and flags pixels with full KxK context.
// Config   : LINE_LEN_CHECK_EN - when defined, every line length is measured
//            against H_SIZE; LOCK_N good lines are needed to lock and a bad
//            line raises len_err and drops back to SYNC.
// Revision : 1.0 - initial release
// ============================================================================
module median_line_ctrl #(
  parameter int H_SIZE = 1664,
  parameter int ADDR_W = 11,
  parameter int LINE_W = 12,
  parameter int K      = 5,
  parameter int LOCK_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_in,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic [LINE_W-1:0] col_cnt,
  output logic [LINE_W-1:0] line_cnt,
  output logic              window_valid,
  output logic              locked,
  output logic              len_err
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_SIZE - 1);
  localparam logic [LINE_W-1:0] CNT_MAX   = '1;
  localparam logic [LINE_W-1:0] WIN_MIN   = LINE_W'(K - 1);

  state_t            state_q, state_d;
  logic              vs_q, de_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_en_q, mem_en_d;
  logic [LINE_W-1:0] col_cnt_q, col_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic              window_valid_q, window_valid_d;
  logic              locked_q, locked_d;
  logic [LINE_W-1:0] cur_col, cur_line;
  logic              vs_rise, de_rise, de_fall;

  // Horizontal sync carries no information the counters need.
  logic unused_h_sync;
  assign unused_h_sync = h_sync_in;

  assign vs_rise = v_sync_in & ~vs_q;
  assign de_rise = de_in & ~de_q;
  assign de_fall = ~de_in & de_q;

`ifdef LINE_LEN_CHECK_EN
  localparam int               LEN_W     = ADDR_W + 1;
  localparam int               GOOD_W    = $clog2(LOCK_N + 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = '1;
  localparam logic [LEN_W-1:0] LEN_GOOD  = LEN_W'(H_SIZE);
  localparam logic [GOOD_W-1:0] GOOD_SAT = GOOD_W'(LOCK_N);
  localparam logic [GOOD_W-1:0] GOOD_PRE = GOOD_W'(LOCK_N - 1);

  logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              seen_q, seen_d;
  logic              len_err_q, len_err_d;

  // Measure rise-to-rise line length and run the lock state machine.
  // len_cnt loads 1 on a rising de, so at the next rise it equals the
  // number of clocks between the two rises.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    seen_d    = seen_q;
    len_err_d = 1'b0;
    len_cnt_d = len_cnt_q;
    if (de_rise)
      len_cnt_d = LEN_W'(1);
    else if (len_cnt_q != LEN_MAX)
      len_cnt_d = len_cnt_q + 1'b1;

    if (vs_rise) begin
      // Frame start wins; a coincident de rise only opens line 0.
      state_d = ST_SYNC;
      good_d  = '0;
      seen_d  = de_rise;
    end else if (de_rise) begin
      seen_d = 1'b1;
      if (seen_q && (state_q != ST_UNLOCKED)) begin
        if (len_cnt_q == LEN_GOOD) begin
          if (good_q != GOOD_SAT)
            good_d = good_q + 1'b1;
          if ((state_q == ST_SYNC) && (good_q >= GOOD_PRE))
            state_d = ST_LOCKED;
        end else begin
          len_err_d = 1'b1;
          good_d    = '0;
          state_d   = ST_SYNC;
        end
      end
    end
  end

  // Length-check registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_cnt_q <= '0;
      good_q    <= '0;
      seen_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      len_cnt_q <= len_cnt_d;
      good_q    <= good_d;
      seen_q    <= seen_d;
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  // Lock state machine without length checking: the first line after a
  // frame start is trusted.
  always_comb begin
    state_d = state_q;
    if (vs_rise)
      state_d = ST_SYNC;
    else if (de_rise && (state_q == ST_SYNC))
      state_d = ST_LOCKED;
  end

  assign len_err = 1'b0;
`endif

  // BRAM address, pixel/line counters and window qualification.
  always_comb begin
    mem_addr_d = mem_addr_q;
    if (vs_rise)
      mem_addr_d = '0;
    else if (mem_en_q)
      mem_addr_d = (mem_addr_q == ADDR_LAST) ? '0 : mem_addr_q + 1'b1;

    // A frame start makes the current pixel (if any) col 0 of line 0.
    cur_col  = vs_rise ? '0 : col_cnt_q;
    cur_line = vs_rise ? '0 : line_cnt_q;

    col_cnt_d = col_cnt_q;
    if (vs_rise)
      col_cnt_d = {{(LINE_W-1){1'b0}}, de_in};
    else if (de_fall)
      col_cnt_d = '0;
    else if (de_in && (col_cnt_q != CNT_MAX))
      col_cnt_d = col_cnt_q + 1'b1;

    line_cnt_d = line_cnt_q;
    if (vs_rise)
      line_cnt_d = '0;
    else if (de_fall && (line_cnt_q != CNT_MAX))
      line_cnt_d = line_cnt_q + 1'b1;

    window_valid_d = de_in & locked_q & (cur_line >= WIN_MIN) & (cur_col >= WIN_MIN);
    locked_d       = (state_d == ST_LOCKED);
    mem_en_d       = (state_d != ST_UNLOCKED);
  end

  // State, edge history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_UNLOCKED;
      vs_q           <= 1'b0;
      de_q           <= 1'b0;
      mem_addr_q     <= '0;
      mem_en_q       <= 1'b0;
      col_cnt_q      <= '0;
      line_cnt_q     <= '0;
      window_valid_q <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      vs_q           <= v_sync_in;
      de_q           <= de_in;
      mem_addr_q     <= mem_addr_d;
      mem_en_q       <= mem_en_d;
      col_cnt_q      <= col_cnt_d;
      line_cnt_q     <= line_cnt_d;
      window_valid_q <= window_valid_d;
      locked_q       <= locked_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_en       = mem_en_q;
  assign col_cnt      = col_cnt_q;
  assign line_cnt     = line_cnt_q;
  assign window_valid = window_valid_q;
  assign locked       = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_median_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_median_line_ctrl
// Purpose  : Directed self-checking bench for median_line_ctrl. Expected
//            values are hand-derived for 1664-clock lines with 1280 active.
// Revision : 1.0 - initial release
// ============================================================================
module tb_median_line_ctrl;

  localparam int H_SIZE = 1664;
  localparam int ADDR_W = 11;
  localparam int LINE_W = 12;
  localparam int K      = 5;
  localparam int LOCK_N = 2;
  localparam int ACT    = 1280;

`ifdef LINE_LEN_CHECK_EN
  localparam int LEN_CHECK = 1;
`else
  localparam int LEN_CHECK = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              de_in;
  logic              h_sync_in;
  logic              v_sync_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [LINE_W-1:0] col_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              window_valid;
  logic              locked;
  logic              len_err;

  int n_checks = 0;
  int n_errors = 0;

  // Per-line observations captured by run_line.
  int first_locked, first_len_err, first_col, first_line, first_addr;
  int err_rest, addr_prelast, addr_last;
  int wv_c3, wv_c4, wv_fall, wv_any, fall_col, fall_line;

  median_line_ctrl #(
    .H_SIZE(H_SIZE), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .K(K), .LOCK_N(LOCK_N)
  ) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in),
    .v_sync_in(v_sync_in), .mem_addr(mem_addr), .mem_en(mem_en),
    .col_cnt(col_cnt), .line_cnt(line_cnt), .window_valid(window_valid),
    .locked(locked), .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Apply one clock of inputs; on return the registered outputs reflect them.
  task automatic step(input logic de, input logic vs, input logic hs);
    de_in     = de;
    v_sync_in = vs;
    h_sync_in = hs;
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int total, input int active, input logic first_vs);
    err_rest = 0;
    wv_any   = 0;
    for (int i = 0; i < total; i++) begin
      step(i < active, (i == 0) ? first_vs : 1'b0, (i >= active + 16) && (i < active + 56));
      if (i == 0) begin
        first_locked  = int'(locked);
        first_len_err = int'(len_err);
        first_col     = int'(col_cnt);
        first_line    = int'(line_cnt);
        first_addr    = int'(mem_addr);
      end else if (len_err) begin
        err_rest = 1;
      end
      if (window_valid) wv_any = 1;
      if (i == 3) wv_c3 = int'(window_valid);
      if (i == 4) wv_c4 = int'(window_valid);
      if (i == active) begin
        wv_fall   = int'(window_valid);
        fall_col  = int'(col_cnt);
        fall_line = int'(line_cnt);
      end
      if (i == total - 2) addr_prelast = int'(mem_addr);
      if (i == total - 1) addr_last = int'(mem_addr);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_addr"}, 32'(mem_addr), 0);
    check({pfx, "_en"}, 32'(mem_en), 0);
    check({pfx, "_col"}, 32'(col_cnt), 0);
    check({pfx, "_line"}, 32'(line_cnt), 0);
    check({pfx, "_wv"}, 32'(window_valid), 0);
    check({pfx, "_locked"}, 32'(locked), 0);
    check({pfx, "_len_err"}, 32'(len_err), 0);
  endtask

  initial begin
    rst       = 1'b1;
    de_in     = 1'b0;
    v_sync_in = 1'b0;
    h_sync_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");

    // 1: idle after reset, no syncs
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    check("idle_en", 32'(mem_en), 0);
    check("idle_addr", 32'(mem_addr), 0);
    check("idle_locked", 32'(locked), 0);

    // 2: frame start, then nominal lines
    step(1'b0, 1'b1, 1'b0);
    check("vs_en", 32'(mem_en), 1);
    check("vs_addr", 32'(mem_addr), 0);
    check("vs_locked", 32'(locked), 0);
    run_line(H_SIZE, ACT, 1'b0);
    check("l1_locked", 32'(first_locked), (LEN_CHECK != 0) ? 0 : 1);
    check("l1_col", 32'(first_col), 1);
    check("l1_line", 32'(first_line), 0);
    check("l1_first_addr", 32'(first_addr), 1);
    check("l1_addr_1663", 32'(addr_prelast), H_SIZE - 1);
    check("l1_addr_wrap", 32'(addr_last), 0);
    check("l1_fall_col", 32'(fall_col), 0);
    check("l1_fall_line", 32'(fall_line), 1);
    check("l1_err", 32'(first_len_err + err_rest), 0);
    run_line(H_SIZE, ACT, 1'b0);
    check("l2_locked", 32'(first_locked), (LEN_CHECK != 0) ? 0 : 1);
    check("l2_err", 32'(first_len_err + err_rest), 0);
    run_line(H_SIZE, ACT, 1'b0);
    check("l3_locked", 32'(first_locked), 1);
    check("l3_err", 32'(first_len_err + err_rest), 0);

    // 3: one short line, then recovery
    run_line(H_SIZE - 1, ACT, 1'b0);
    check("short_err", 32'(first_len_err + err_rest), 0);
    run_line(H_SIZE, ACT, 1'b0);
    check("bad_len_err", 32'(first_len_err), LEN_CHECK);
    check("bad_locked", 32'(first_locked), (LEN_CHECK != 0) ? 0 : 1);
    check("bad_err_width", 32'(err_rest), 0);
    run_line(H_SIZE, ACT, 1'b0);
    check("re1_locked", 32'(first_locked), (LEN_CHECK != 0) ? 0 : 1);
    check("re1_err", 32'(first_len_err), 0);
    run_line(H_SIZE, ACT, 1'b0);
    check("re2_locked", 32'(first_locked), 1);

    // 4: window_valid border masking on a fresh frame
    step(1'b0, 1'b1, 1'b0);
    check("f_line0", 32'(line_cnt), 0);
    check("f_addr0", 32'(mem_addr), 0);
    for (int ln = 0; ln < 4; ln++) begin
      run_line(H_SIZE, ACT, 1'b0);
      check("border_row_wv", 32'(wv_any), 0);
    end
    run_line(H_SIZE, ACT, 1'b0);
    check("r4_line", 32'(first_line), 4);
    check("r4_locked", 32'(first_locked), 1);
    check("r4_c3_wv", 32'(wv_c3), 0);
    check("r4_c4_wv", 32'(wv_c4), 1);
    check("r4_fall_wv", 32'(wv_fall), 0);

    // 5: frame start coinciding with line start
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    run_line(H_SIZE, ACT, 1'b1);
    check("co_addr", 32'(first_addr), 0);
    check("co_line", 32'(first_line), 0);
    check("co_col", 32'(first_col), 1);
    check("co_len_err", 32'(first_len_err + err_rest), 0);
    run_line(H_SIZE, ACT, 1'b0);
    check("co_next_len_err", 32'(first_len_err + err_rest), 0);
    check("co_next_line", 32'(first_line), 1);

    // 6: asynchronous reset in the middle of a locked line
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
    check("pre_rst_locked", 32'(locked), 1);
    check("pre_rst_en", 32'(mem_en), 1);
    check("pre_rst_col", 32'(col_cnt), 100);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1 rst = 1'b0;
    for (int i = 100; i < H_SIZE; i++) step(i < ACT, 1'b0, 1'b0);
    run_line(H_SIZE, ACT, 1'b0);
    check("post_rst_locked", 32'(locked), 0);
    check("post_rst_en", 32'(mem_en), 0);
    check("post_rst_addr", 32'(mem_addr), 0);
    check("post_rst_err", 32'(first_len_err + err_rest), 0);
    step(1'b0, 1'b1, 1'b0);
    check("relock_vs_en", 32'(mem_en), 1);
    run_line(H_SIZE, ACT, 1'b0);
    check("relock_l1", 32'(first_locked), (LEN_CHECK != 0) ? 0 : 1);
    run_line(H_SIZE, ACT, 1'b0);
    run_line(H_SIZE, ACT, 1'b0);
    check("relock_l3", 32'(first_locked), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
